// File: rtl/if_pkg.sv
// Shared definitions for the SimpleMIPS instruction-fetch stage.
// Contents:
//   IF_RESET_PC    default fetch address after reset
//   IF_PC_INC      byte distance between consecutive instruction words
//   fetch_entry_t  {instr, pc} record held in the fetch queue (default widths)
package if_pkg;

  localparam logic [31:0] IF_RESET_PC      = 32'h0000_3000;
  localparam int unsigned IF_PC_INC        = 32'd4;
  localparam int unsigned IF_ENTRY_ADDR_W  = 32'd32;
  localparam int unsigned IF_ENTRY_INSTR_W = 32'd32;

  typedef struct packed {
    logic [IF_ENTRY_INSTR_W-1:0] instr;
    logic [IF_ENTRY_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_chk.sv
// Invariant checker for the fetch stage credit and drop accounting.
// Ports (all inputs):
//   clk, rst         clock and reset (checks disabled while reset is high)
//   q_count          fetch queue occupancy
//   outst            live requests in flight
//   drop_cnt         stale responses still to be discarded
//   imem_resp_valid  memory response strobe
//   q_push, q_full   queue write strobe and full flag
module if_fetch_queue_chk #(
  parameter int QDEPTH    = 4,
  parameter int MAX_OUTST = 2
) (
  input logic                          clk,
  input logic                          rst,
  input logic [$clog2(QDEPTH):0]       q_count,
  input logic [$clog2(QDEPTH):0]       outst,
  input logic [$clog2(MAX_OUTST):0]    drop_cnt,
  input logic                          imem_resp_valid,
  input logic                          q_push,
  input logic                          q_full
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int DW = $clog2(MAX_OUTST) + 1;
  localparam int TW = CW + 1;

  logic [TW-1:0] inflight_s;
  logic [TW-1:0] occ_s;

  // Sums used by several properties.
  always_comb begin
    inflight_s = TW'(outst) + TW'(drop_cnt);
    occ_s      = TW'(q_count) + TW'(outst);
  end

  a_resp_expected: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (inflight_s != '0));

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(q_push && q_full));

  a_outst_max: assert property (@(posedge clk) disable iff (rst)
    outst <= CW'(MAX_OUTST));

  a_drop_max: assert property (@(posedge clk) disable iff (rst)
    drop_cnt <= DW'(MAX_OUTST));

  a_occ_max: assert property (@(posedge clk) disable iff (rst)
    occ_s <= TW'(QDEPTH));

endmodule

// File: rtl/if_fifo.sv
// Parametrised synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push, wdata  write request and data (ignored when full)
//   pop          consume head (ignored when empty)
//   flush        empty the FIFO; takes priority over push and pop
//   rdata        head entry, valid whenever empty is low
//   count        number of stored entries (0..DEPTH)
//   empty, full  status flags derived from count
module if_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify requests against the current fill level.
  always_comb begin
    do_push_s = push && (count_r != (AW+1)'(DEPTH));
    do_pop_s  = pop && (count_r != '0);
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == '0);
  assign full  = (count_r == (AW+1)'(DEPTH));

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a variable-latency request/response memory
// port, several fetches in flight and an FWFT fetch queue feeding ID.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   redirect, redirect_pc           flush and restart fetch (pc bits [1:0] ignored)
//   imem_req_valid/ready/addr       fetch request handshake, word-aligned address
//   imem_resp_valid/data            in-order read data from memory
//   out_valid/ready                 queue head handshake towards ID
//   out_instr, out_pc, out_npc      head instruction, its pc and pc+4
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                INSTR_W   = 32,
  parameter int                QDEPTH    = 4,
  parameter int                MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(IF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_npc
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int DW = $clog2(MAX_OUTST) + 1;
  localparam int TW = CW + 1;
  localparam int EW = INSTR_W + ADDR_W;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(IF_PC_INC);

  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] resp_pc_r;
  logic [CW-1:0]     outst_r;
  logic [DW-1:0]     drop_cnt_r;

  logic [ADDR_W-1:0] redirect_al_s;
  logic [CW-1:0]     q_count_s;
  logic [TW-1:0]     occ_s;
  logic [TW-1:0]     inflight_s;
  logic [TW-1:0]     drop_next_s;
  logic              issue_s;
  logic              accept_s;
  logic              live_s;
  logic              drop_s;
  logic              pop_s;
  logic              q_empty_s;
  logic              q_full_s;
  logic [EW-1:0]     q_wdata_s;
  logic [EW-1:0]     q_rdata_s;

  // Issue, credit and response classification.
  always_comb begin
    redirect_al_s = redirect_pc & ~ADDR_W'(3);
    // Queue slots are reserved by live requests, so count+outst bounds issue.
    occ_s         = TW'(q_count_s) + TW'(outst_r);
    // Stale requests still occupy memory-side slots until their data returns.
    inflight_s    = TW'(outst_r) + TW'(drop_cnt_r);
    if (!rst && !redirect && (occ_s < TW'(QDEPTH)) && (inflight_s < TW'(MAX_OUTST))) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    accept_s = issue_s && imem_req_ready;
    // A response in a redirect cycle is stale by definition and folded into drop_next_s.
    live_s   = imem_resp_valid && !redirect && (drop_cnt_r == '0) && (outst_r != '0);
    drop_s   = imem_resp_valid && !redirect && (drop_cnt_r != '0);
    if (imem_resp_valid && (inflight_s != '0)) begin
      drop_next_s = inflight_s - TW'(1);
    end else begin
      drop_next_s = inflight_s;
    end
    pop_s     = !q_empty_s && out_ready;
    q_wdata_s = {imem_resp_data, resp_pc_r};
  end

  // Fetch/response pc tracking and in-flight accounting; redirect has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      outst_r    <= '0;
      drop_cnt_r <= '0;
    end else if (redirect) begin
      fetch_pc_r <= redirect_al_s;
      resp_pc_r  <= redirect_al_s;
      outst_r    <= '0;
      drop_cnt_r <= DW'(drop_next_s);
    end else begin
      if (accept_s) begin
        fetch_pc_r <= fetch_pc_r + PC_INC;
      end
      if (live_s) begin
        resp_pc_r <= resp_pc_r + PC_INC;
      end
      case ({accept_s, live_s})
        2'b10:   outst_r <= outst_r + CW'(1);
        2'b01:   outst_r <= outst_r - CW'(1);
        default: outst_r <= outst_r;
      endcase
      if (drop_s) begin
        drop_cnt_r <= drop_cnt_r - DW'(1);
      end
    end
  end

  if_fifo #(
    .W     (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (live_s),
    .wdata (q_wdata_s),
    .pop   (pop_s),
    .flush (redirect),
    .rdata (q_rdata_s),
    .count (q_count_s),
    .empty (q_empty_s),
    .full  (q_full_s)
  );

  if_fetch_queue_chk #(
    .QDEPTH    (QDEPTH),
    .MAX_OUTST (MAX_OUTST)
  ) u_chk (
    .clk             (clk),
    .rst             (rst),
    .q_count         (q_count_s),
    .outst           (outst_r),
    .drop_cnt        (drop_cnt_r),
    .imem_resp_valid (imem_resp_valid),
    .q_push          (live_s),
    .q_full          (q_full_s)
  );

  assign imem_req_valid = issue_s;
  assign imem_req_addr  = fetch_pc_r;
  assign out_valid      = !q_empty_s;
  assign out_instr      = q_rdata_s[EW-1:ADDR_W];
  assign out_pc         = q_rdata_s[ADDR_W-1:0];
  assign out_npc        = q_rdata_s[ADDR_W-1:0] + PC_INC;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed testbench for if_fetch_queue with a behavioural in-order memory
// of programmable latency. Memory returns instr = ~addr.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_npc;

  if_fetch_queue #(
    .ADDR_W    (32),
    .INSTR_W   (32),
    .QDEPTH    (4),
    .MAX_OUTST (2),
    .RESET_PC  (32'h0000_3000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_npc         (out_npc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] r_addr[$];
  logic [31:0] d_pc[$];
  logic [31:0] d_npc[$];
  logic [31:0] d_ins[$];

  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_out_valid;
  logic [31:0] s_out_pc;
  logic [31:0] a0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] req_at(input int i);
    if (i < r_addr.size()) return r_addr[i];
    else return 32'hBAD0_0000;
  endfunction

  function automatic logic [31:0] pc_at(input int i);
    if (i < d_pc.size()) return d_pc[i];
    else return 32'hBAD0_0001;
  endfunction

  function automatic logic [31:0] npc_at(input int i);
    if (i < d_npc.size()) return d_npc[i];
    else return 32'hBAD0_0002;
  endfunction

  function automatic logic [31:0] ins_at(input int i);
    if (i < d_ins.size()) return d_ins[i];
    else return 32'hBAD0_0003;
  endfunction

  // One clock cycle: present memory response, sample outputs, log handshakes.
  task automatic tick();
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = ~mq_addr[0];
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_out_valid = out_valid;
    s_out_pc    = out_pc;
    if (imem_resp_valid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      r_addr.push_back(imem_req_addr);
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
    end
    if (out_valid && out_ready) begin
      d_pc.push_back(out_pc);
      d_npc.push_back(out_npc);
      d_ins.push_back(out_instr);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_logs();
    r_addr.delete();
    d_pc.delete();
    d_npc.delete();
    d_ins.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    imem_resp_valid = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    repeat (2) tick();
    check("rst_req_valid", 32'(s_req_valid), 32'h0);
    check("rst_out_valid", 32'(s_out_valid), 32'h0);
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    out_ready = 1'b1;
    #1;
    check("t0_req_valid", 32'(imem_req_valid), 32'h0);
    check("t0_out_valid", 32'(out_valid), 32'h0);

    // Straight-line fetch, latency 1.
    lat = 1;
    do_reset();
    repeat (10) tick();
    check("sl_nreq", 32'(r_addr.size()), 32'd10);
    check("sl_ndel", 32'(d_pc.size()), 32'd8);
    check("sl_req2", req_at(2), 32'h0000_3008);
    check("sl_pc0", pc_at(0), 32'h0000_3000);
    check("sl_npc0", npc_at(0), 32'h0000_3004);
    check("sl_pc1", pc_at(1), 32'h0000_3004);
    check("sl_npc1", npc_at(1), 32'h0000_3008);
    check("sl_ins0", ins_at(0), 32'hFFFF_CFFF);

    // Stall ID for 10 cycles: exactly 4 entries buffered.
    do_reset();
    out_ready = 1'b0;
    repeat (10) tick();
    check("st_nreq", 32'(r_addr.size()), 32'd4);
    check("st_lastreq", req_at(3), 32'h0000_300C);
    check("st_req_valid", 32'(s_req_valid), 32'h0);
    check("st_out_valid", 32'(s_out_valid), 32'h1);
    check("st_head", s_out_pc, 32'h0000_3000);
    out_ready = 1'b1;
    repeat (8) tick();
    check("st_ndel", 32'(d_pc.size()), 32'd8);
    check("st_pc0", pc_at(0), 32'h0000_3000);
    check("st_pc3", pc_at(3), 32'h0000_300C);
    check("st_pc4", pc_at(4), 32'h0000_3010);

    // Redirect with two requests in flight, latency 3.
    lat = 3;
    do_reset();
    repeat (2) tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_3041;
    tick();
    redirect = 1'b0;
    repeat (12) tick();
    check("rd2_req2", req_at(2), 32'h0000_3040);
    check("rd2_pc0", pc_at(0), 32'h0000_3040);
    check("rd2_npc0", npc_at(0), 32'h0000_3044);
    check("rd2_ins0", ins_at(0), 32'hFFFF_CFBF);
    check("rd2_pc1", pc_at(1), 32'h0000_3044);

    // Redirect in the same cycle as the 0x3008 response, latency 1.
    lat = 1;
    do_reset();
    repeat (3) tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_3100;
    tick();
    check("rdr_req_valid", 32'(s_req_valid), 32'h0);
    redirect = 1'b0;
    tick();
    check("rdr_flushed", 32'(s_out_valid), 32'h0);
    repeat (5) tick();
    check("rdr_req3", req_at(3), 32'h0000_3100);
    check("rdr_pc1", pc_at(1), 32'h0000_3004);
    check("rdr_pc2", pc_at(2), 32'h0000_3100);
    check("rdr_pc3", pc_at(3), 32'h0000_3104);

    // Memory backpressure, then redirect to the top of the address space.
    do_reset();
    imem_req_ready = 1'b0;
    tick();
    a0 = s_req_addr;
    check("bp_valid0", 32'(s_req_valid), 32'h1);
    tick();
    check("bp_addr0", a0, 32'h0000_3000);
    check("bp_hold0", s_req_addr, 32'h0000_3000);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    check("bp_hold1", s_req_addr, 32'h0000_3004);
    imem_req_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    clear_logs();
    repeat (6) tick();
    check("wr_req0", req_at(0), 32'hFFFF_FFFC);
    check("wr_req1", req_at(1), 32'h0000_0000);
    check("wr_pc0", pc_at(0), 32'hFFFF_FFFC);
    check("wr_npc0", npc_at(0), 32'h0000_0000);
    check("wr_ins0", ins_at(0), 32'h0000_0003);
    check("wr_pc1", pc_at(1), 32'h0000_0000);
    check("wr_npc1", npc_at(1), 32'h0000_0004);

    // Asynchronous reset between edges with entries queued and requests in flight.
    lat = 3;
    do_reset();
    out_ready = 1'b0;
    repeat (5) tick();
    imem_resp_valid = 1'b0;
    #1;
    check("ar_pre_out_valid", 32'(out_valid), 32'h1);
    check("ar_pre_req_valid", 32'(imem_req_valid), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'h0);
    check("ar_req_valid", 32'(imem_req_valid), 32'h0);
    repeat (4) tick();
    check("ar_hold_out_valid", 32'(s_out_valid), 32'h0);
    rst = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    clear_logs();
    lat = 1;
    out_ready = 1'b1;
    repeat (6) tick();
    check("ar_req0", req_at(0), 32'h0000_3000);
    check("ar_pc0", pc_at(0), 32'h0000_3000);
    check("ar_pc1", pc_at(1), 32'h0000_3004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
